matrix_mac_datapath: RTL and testbench
======================================

# matrix_mac_datapath

Operand store and multiply-accumulate datapath for the 2x2 matrix multiplier. It accepts the eight operand elements from the upstream stream and raises `start` to the controller. Driven by the controller's `load_matrix`/`count`/`acc_en`/`entry`/`done`, it forms the eight partial products and the four result sums. It then streams the four results downstream over a valid/ready handshake.

## Interface
- `WIDTH`, 8, signed operand element width; result width is 2*WIDTH+1.
- `clock`  in  1  sole clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `op_valid`  in  1  upstream operand present.
- `op_ready`  out  1  block accepts operand (high only in LOAD).
- `op_data`  in  WIDTH  signed operand, order A00,A01,A10,A11,B00,B01,B10,B11.
- `start`  out  1  one-cycle pulse to controller: operands complete.
- `load_matrix`  in  1  controller: product phase strobe.
- `count`  in  3  controller: product index {i,j,k}.
- `acc_en`  in  1  controller: accumulate strobe.
- `entry`  in  2  controller: result index {i,j}.
- `done`  in  1  controller: results final.
- `res_valid`  out  1  result word present.
- `res_ready`  in  1  downstream accepts result.
- `res_data`  out  2*WIDTH+1  signed result C[entry], order C00,C01,C10,C11.

## Operation
- States: LOAD, COMPUTE, DRAIN. Reset -> LOAD.
- LOAD: `op_ready`=1. Each edge with `op_valid`&`op_ready` writes `op_data` to slot ld_idx (0..7), ld_idx++. Accept of slot 7 -> COMPUTE, ld_idx wraps to 0, `start` pulses.
- COMPUTE: `op_ready`=0.
  - `load_matrix`=1: P[count] <= A[i][k]*B[k][j] (signed, 2*WIDTH bits), with i=count[2], j=count[1], k=count[0].
  - `acc_en`=1 and `load_matrix`=0: C[entry] <= sext(P[{entry,0}]) + sext(P[{entry,1}]), 2*WIDTH+1 bits; no overflow possible.
  - Both high in same cycle: product write only, accumulate ignored.
  - `done` rising (1 now, 0 previous cycle): -> DRAIN, rd_idx=0. A `done` held high does not retrigger.
- DRAIN: `res_valid`=1, `res_data`=C[rd_idx]. Edge with `res_valid`&`res_ready` -> rd_idx++. Accept of rd_idx 3 -> LOAD.
- Control inputs (`load_matrix`, `acc_en`, `count`, `entry`, `done`) ignored in LOAD and DRAIN. `op_valid` ignored outside LOAD.
- P and C retain values across operations; they are cleared only by reset. Unwritten C entries drain as their previous/reset value.

## Timing
- Reset values: `op_ready`=1 (state LOAD), `start`=0, `res_valid`=0, `res_data`=0, all A/B/P/C, ld_idx, rd_idx = 0.
- `start` is registered: high exactly the one cycle after the edge accepting slot 7.
- Product latency 1: P[count] visible the cycle after `load_matrix` sampled. `acc_en` in cycle t reads P written at or before edge t.
- Accumulate latency 1: C[entry] updated at the sampling edge.
- `done` rising sampled at edge t -> `res_valid`=1 from cycle t+1.
- `res_data` stable while `res_valid`&!`res_ready`. Back-to-back accepts drain 4 results in 4 cycles.
- Last result accepted at edge t -> `op_ready`=1 in cycle t+1. No operand accepted in the same cycle as a result.
- Reset mid-operation (any state): immediate return to LOAD, outputs to reset values, partial operand/result progress discarded.

## Test plan
- Reset then 8 operands A=[[1,2],[3,4]], B=[[5,6],[7,8]] with `op_valid` held -> `op_ready` drops after 8th, `start` one cycle. Controller sequence (count 0..7, entry 0..3, `done`) -> results 19, 22, 43, 50 in order.
- All operands -128 (WIDTH=8) -> each result 32768 (17-bit 0x08000). A=[[-1,0],[0,-1]], B=[[5,6],[7,8]] -> -5, -6, -7, -8.
- Operand bubbles (`op_valid` toggling) and `res_ready` stalls of 3 cycles per word -> same results. `res_data` stable during stall. Exactly 8 accepts and 4 accepts.
- `load_matrix` and `acc_en` high together on count=0/entry=0 -> P[0] written, C[0] unchanged. `done` held high 5 cycles -> single drain of 4 words.
- Control strobes and `done` pulsed during LOAD and DRAIN -> no P/C change, no state change.
- Reset asserted after 5 operands, and again after 2 results drained -> `op_ready`=1, `res_valid`=0, `start`=0. A fresh full run yields 19, 22, 43, 50.

Source files
------------

// File: rtl/matrix_mac_datapath_if.sv
// matrix_mac_datapath_if: operand stream, controller strobes and result stream of the 2x2 MAC datapath
// master drives operands, controller strobes and res_ready; slave (the datapath) returns op_ready, start and results
interface matrix_mac_datapath_if #(parameter int WIDTH = 8);
  logic               op_valid;
  logic               op_ready;
  logic [WIDTH-1:0]   op_data;
  logic               start;
  logic               load_matrix;
  logic [2:0]         count;
  logic               acc_en;
  logic [1:0]         entry;
  logic               done;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH:0]   res_data;
  modport master (
    output op_valid, op_data, load_matrix, count, acc_en, entry, done, res_ready,
    input  op_ready, start, res_valid, res_data
  );
  modport slave (
    input  op_valid, op_data, load_matrix, count, acc_en, entry, done, res_ready,
    output op_ready, start, res_valid, res_data
  );
endinterface

// File: rtl/matrix_mac_datapath.sv
// matrix_mac_datapath: operand store and multiply-accumulate datapath of the 2x2 matrix multiplier
// ports: clock, reset (async, active-high), bus (slave): operand stream in, start pulse out,
// controller strobes load_matrix/count/acc_en/entry/done in, result stream C00..C11 out
module matrix_mac_datapath #(
  parameter int WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset,
  matrix_mac_datapath_if.slave bus
);
  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;
  state_t                   state_q, state_d;
  logic [2:0]               ld_idx_q, ld_idx_d;
  logic [1:0]               rd_idx_q, rd_idx_d;
  logic                     start_q, start_d;
  logic                     done_prev_q;
  logic signed [WIDTH-1:0]  ops_q [8];
  logic signed [WIDTH-1:0]  ops_d [8];
  logic signed [2*WIDTH-1:0] p_q [8];
  logic signed [2*WIDTH-1:0] p_d [8];
  logic signed [2*WIDTH:0]  c_q [4];
  logic signed [2*WIDTH:0]  c_d [4];
  logic signed [WIDTH-1:0]  a_op, b_op;
  logic signed [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0]       p_lo, p_hi;
  logic signed [2*WIDTH:0]  sum;
  assign bus.op_ready  = state_q == LOAD;
  assign bus.res_valid = state_q == DRAIN;
  assign bus.res_data  = bus.res_valid ? c_q[rd_idx_q] : '0;
  assign bus.start     = start_q;
  always_comb begin
    // slots 0..3 hold A row-major, 4..7 hold B row-major; count = {i,j,k}
    a_op = ops_q[{1'b0, bus.count[2], bus.count[0]}];
    b_op = ops_q[{1'b1, bus.count[0], bus.count[1]}];
    prod = $signed({{WIDTH{a_op[WIDTH-1]}}, a_op}) * $signed({{WIDTH{b_op[WIDTH-1]}}, b_op});
    p_lo = p_q[{bus.entry, 1'b0}];
    p_hi = p_q[{bus.entry, 1'b1}];
    sum = $signed({p_lo[2*WIDTH-1], p_lo}) + $signed({p_hi[2*WIDTH-1], p_hi});
    state_d  = state_q;
    ld_idx_d = ld_idx_q;
    rd_idx_d = rd_idx_q;
    start_d  = 1'b0;
    ops_d    = ops_q;
    p_d      = p_q;
    c_d      = c_q;
    if (state_q == LOAD && bus.op_valid) begin
      ops_d[ld_idx_q] = bus.op_data;
      ld_idx_d = ld_idx_q + 3'd1;
      state_d  = ld_idx_q == 3'd7 ? COMPUTE : LOAD;
      start_d  = ld_idx_q == 3'd7;
    end
    if (state_q == COMPUTE) begin
      // a product write wins over a simultaneous accumulate
      if (bus.load_matrix) p_d[bus.count] = prod;
      else if (bus.acc_en) c_d[bus.entry] = sum;
      if (bus.done && !done_prev_q) begin
        state_d  = DRAIN;
        rd_idx_d = 2'd0;
      end
    end
    if (state_q == DRAIN && bus.res_ready) begin
      rd_idx_d = rd_idx_q + 2'd1;
      state_d  = rd_idx_q == 2'd3 ? LOAD : DRAIN;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      ld_idx_q    <= '0;
      rd_idx_q    <= '0;
      start_q     <= 1'b0;
      done_prev_q <= 1'b0;
      ops_q       <= '{default: '0};
      p_q         <= '{default: '0};
      c_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      ld_idx_q    <= ld_idx_d;
      rd_idx_q    <= rd_idx_d;
      start_q     <= start_d;
      done_prev_q <= bus.done;
      ops_q       <= ops_d;
      p_q         <= p_d;
      c_q         <= c_d;
    end
  end
endmodule

// File: tb/tb_matrix_mac_datapath.sv
// tb_matrix_mac_datapath: scenario tasks with a result scoreboard for matrix_mac_datapath
module tb_matrix_mac_datapath;
  typedef int vec8_t [8];
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  matrix_mac_datapath_if #(.WIDTH(8)) bus ();
  matrix_mac_datapath #(.WIDTH(8)) dut (.clock(clk), .reset(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int exp_q [$];
  int ops_m [8];
  int p_m [8];
  int c_m [4];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    bus.op_valid = 1'b0; bus.op_data = '0; bus.load_matrix = 1'b0; bus.count = '0;
    bus.acc_en = 1'b0; bus.entry = '0; bus.done = 1'b0; bus.res_ready = 1'b0;
  endtask
  task automatic model_reset;
    foreach (ops_m[i]) ops_m[i] = 0;
    foreach (p_m[i]) p_m[i] = 0;
    foreach (c_m[i]) c_m[i] = 0;
    exp_q.delete();
  endtask
  task automatic release_reset;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic load_part(input vec8_t v, input int lo, input int hi, input bit bubbles);
    int idx = lo;
    int cyc = 0;
    while (idx < hi && cyc < 200) begin
      bus.op_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.op_data = 8'(v[idx]);
      tests++;
      if (bus.op_ready !== 1'b1) begin
        fails++;
        $display("FAIL load_ready slot %0d: got op_ready=%b want 1", idx, bus.op_ready);
      end
      if (bus.op_valid) begin
        ops_m[idx] = v[idx];
        idx++;
      end
      tick;
      cyc++;
    end
    bus.op_valid = 1'b0;
    tests++;
    if (idx != hi) begin
      fails++;
      $display("FAIL load_timeout: got %0d slots want %0d", idx, hi);
    end
  endtask
  task automatic finish_load;
    tests++;
    if (bus.op_ready !== 1'b0 || bus.start !== 1'b1) begin
      fails++;
      $display("FAIL load_end: got op_ready=%b start=%b want 0 1", bus.op_ready, bus.start);
    end
    tick;
    tests++;
    if (bus.start !== 1'b0 || bus.op_ready !== 1'b0) begin
      fails++;
      $display("FAIL start_pulse: got start=%b op_ready=%b want 0 0", bus.start, bus.op_ready);
    end
  endtask
  task automatic load_all(input vec8_t v, input bit bubbles);
    load_part(v, 0, 8, bubbles);
    finish_load;
  endtask
  task automatic prod(input int c, input bit with_acc, input int e);
    int i = (c >> 2) & 1;
    int j = (c >> 1) & 1;
    int k = c & 1;
    bus.load_matrix = 1'b1; bus.count = 3'(c); bus.acc_en = with_acc; bus.entry = 2'(e);
    tick;
    bus.load_matrix = 1'b0; bus.acc_en = 1'b0;
    p_m[c] = ops_m[i*2+k] * ops_m[4+k*2+j];
  endtask
  task automatic acc(input int e);
    bus.acc_en = 1'b1; bus.entry = 2'(e);
    tick;
    bus.acc_en = 1'b0;
    c_m[e] = p_m[2*e] + p_m[2*e+1];
  endtask
  task automatic compute_all;
    for (int c = 0; c < 8; c++) prod(c, 1'b0, 0);
    for (int e = 0; e < 4; e++) acc(e);
  endtask
  task automatic fire_done(input int n);
    foreach (c_m[i]) exp_q.push_back(c_m[i]);
    bus.done = 1'b1;
    tick;
    tests++;
    if (bus.res_valid !== 1'b1) begin
      fails++;
      $display("FAIL done_to_drain: got res_valid=%b want 1", bus.res_valid);
    end
    repeat (n - 1) tick;
    bus.done = 1'b0;
  endtask
  task automatic drain(input int n, input int stall);
    int exp, got;
    logic [16:0] hold;
    for (int w = 0; w < n; w++) begin
      exp = exp_q.size() > 0 ? exp_q.pop_front() : 0;
      hold = bus.res_data;
      for (int s = 0; s < stall; s++) begin
        bus.res_ready = 1'b0;
        tick;
        tests++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== hold) begin
          fails++;
          $display("FAIL stall_hold word %0d: got valid=%b data=%h want 1 %h", w, bus.res_valid, bus.res_data, hold);
        end
      end
      bus.res_ready = 1'b1;
      got = int'($signed(bus.res_data));
      tests++;
      if (bus.res_valid !== 1'b1 || got !== exp) begin
        fails++;
        $display("FAIL result word %0d: got valid=%b data=%0d want 1 %0d", w, bus.res_valid, got, exp);
      end
      tick;
      bus.res_ready = 1'b0;
    end
    if (n == 4) begin
      tests++;
      if (bus.op_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
        fails++;
        $display("FAIL drain_end: got op_ready=%b res_valid=%b want 1 0", bus.op_ready, bus.res_valid);
      end
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    tests++;
    if (bus.op_ready !== 1'b1 || bus.start !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== '0) begin
      fails++;
      $display("FAIL %s: got op_ready=%b start=%b res_valid=%b res_data=%h want 1 0 0 0",
               tag, bus.op_ready, bus.start, bus.res_valid, bus.res_data);
    end
  endtask
  task automatic test_reset;
    idle_inputs;
    rst = 1'b1;
    #2;
    model_reset;
    check_idle_outputs("reset_state");
    release_reset;
    check_idle_outputs("after_reset");
  endtask
  task automatic test_basic;
    load_all('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0);
    compute_all;
    fire_done(1);
    drain(4, 0);
  endtask
  task automatic test_extremes;
    load_all('{-128, -128, -128, -128, -128, -128, -128, -128}, 1'b0);
    compute_all;
    fire_done(1);
    drain(4, 0);
    load_all('{-1, 0, 0, -1, 5, 6, 7, 8}, 1'b0);
    compute_all;
    fire_done(1);
    drain(4, 0);
  endtask
  task automatic test_bubbles_stalls;
    load_all('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b1);
    compute_all;
    fire_done(1);
    drain(4, 3);
  endtask
  task automatic test_both_strobes;
    load_all('{2, 3, 4, 5, 6, 7, 8, 9}, 1'b0);
    for (int c = 1; c < 8; c++) prod(c, 1'b0, 0);
    prod(0, 1'b1, 0);
    for (int e = 1; e < 4; e++) acc(e);
    fire_done(5);
    drain(4, 0);
    load_all('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0);
    acc(0);
    fire_done(1);
    drain(4, 1);
  endtask
  task automatic stray_strobes(input bit in_load);
    for (int c = 0; c < 12; c++) begin
      bus.load_matrix = c < 8; bus.acc_en = c >= 8; bus.count = 3'(c); bus.entry = 2'(c);
      bus.done = c[0];
      tick;
      tests++;
      if (bus.op_ready !== in_load || bus.res_valid !== !in_load || bus.start !== 1'b0) begin
        fails++;
        $display("FAIL stray_%s cycle %0d: got op_ready=%b res_valid=%b start=%b", in_load ? "load" : "drain",
                 c, bus.op_ready, bus.res_valid, bus.start);
      end
    end
    bus.load_matrix = 1'b0; bus.acc_en = 1'b0; bus.done = 1'b0;
  endtask
  task automatic test_ignored_controls;
    vec8_t z = '{9, 9, 9, 9, 1, 1, 1, 1};
    load_part(z, 0, 4, 1'b0);
    stray_strobes(1'b1);
    load_part(z, 4, 8, 1'b0);
    finish_load;
    fire_done(1);
    stray_strobes(1'b0);
    drain(4, 0);
  endtask
  task automatic test_reset_mid;
    load_part('{1, 2, 3, 4, 5, 6, 7, 8}, 0, 5, 1'b0);
    rst = 1'b1;
    #2;
    model_reset;
    check_idle_outputs("reset_in_load");
    release_reset;
    test_basic_partial;
    rst = 1'b1;
    #2;
    model_reset;
    check_idle_outputs("reset_in_drain");
    release_reset;
    test_basic;
  endtask
  task automatic test_basic_partial;
    load_all('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0);
    compute_all;
    fire_done(1);
    drain(2, 0);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_bubbles_stalls;
    test_both_strobes;
    test_ignored_controls;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
